// File: rtl/fp_adder_param.sv
// fp_adder_param: parametrised multicycle IEEE-754-style adder/subtractor.
// Fixed five-cycle latency, round-to-nearest-even, gradual underflow.
module fp_adder_param #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [EXP_W+FRAC_W:0] AddendA,
  input  logic [EXP_W+FRAC_W:0] AddendB,
  input  logic                  Sub,
  input  logic                  Go,
  output logic [EXP_W+FRAC_W:0] Result,
  output logic                  Ready,
  output logic                  Done,
  output logic                  Zero,
  output logic                  Inf,
  output logic                  Nan
);
  localparam int unsigned W  = 1 + EXP_W + FRAC_W;
  localparam int unsigned SW = FRAC_W + 1;   // significand incl. hidden bit
  localparam int unsigned XW = SW + 3;       // significand + guard/round/sticky
  localparam int unsigned WW = 2 * SW + 2;   // alignment window
  localparam int unsigned EW = EXP_W + 1;    // exponent with overflow headroom
  localparam int unsigned RW = SW + 1;       // rounded significand with carry
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADD    = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;

  logic [2:0]        state, state_n;
  logic              load, ready_n, done_n;

  logic [W-1:0]      a_q, b_q;
  logic              sub_q;
  logic              sa_q, sb_q;
  logic [EXP_W-1:0]  ea_q, eb_q;
  logic [SW-1:0]     ma_q, mb_q;
  logic              spec_q;
  logic [W-1:0]      spec_res_q;
  logic              sign_q, eff_sub_q;
  logic [EW-1:0]     exp_q;
  logic [XW-1:0]     big_q, small_q;
  logic [XW:0]       sum_q;
  logic [XW-1:0]     mant_q;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state; a new operation may start from IDLE or straight out of ROUND
  always_comb begin
    state_n = state;
    load    = 1'b0;
    ready_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        if (Go) begin
          state_n = S_UNPACK;
          load    = 1'b1;
          ready_n = 1'b0;
        end
      end
      S_UNPACK: state_n = S_ALIGN;
      S_ALIGN:  state_n = S_ADD;
      S_ADD:    state_n = S_NORM;
      S_NORM:   state_n = S_ROUND;
      S_ROUND: begin
        done_n = 1'b1;
        if (Go) begin
          state_n = S_UNPACK;
          load    = 1'b1;
        end else begin
          state_n = S_IDLE;
          ready_n = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

  // Unpack: field split, classification and special-case result
  logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, spec_n;
  logic [EXP_W-1:0] ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic [W-1:0]     spec_res_n;

  always_comb begin
    sa     = a_q[W-1];
    sb     = b_q[W-1] ^ sub_q;
    ea     = a_q[W-2:FRAC_W];
    eb     = b_q[W-2:FRAC_W];
    fa     = a_q[FRAC_W-1:0];
    fb     = b_q[FRAC_W-1:0];
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    a_zero = (ea == '0) && (fa == '0);
    b_zero = (eb == '0) && (fb == '0);
    spec_n     = 1'b1;
    spec_res_n = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) spec_res_n = QNAN;
    else if (a_inf)            spec_res_n = {sa, EXP_ONES, {FRAC_W{1'b0}}};
    else if (b_inf)            spec_res_n = {sb, EXP_ONES, {FRAC_W{1'b0}}};
    else if (a_zero && b_zero) spec_res_n = {sa & sb, {(W-1){1'b0}}};
    else                       spec_n = 1'b0;
  end

  // Align: larger magnitude first, smaller shifted right with sticky collapse
  logic             a_big, s_big, s_sml;
  logic [EXP_W-1:0] e_big, e_sml, diff;
  logic [SW-1:0]    m_big, m_sml;
  logic [31:0]      ash;
  logic [WW-1:0]    win;
  logic [XW-1:0]    small_n;

  always_comb begin
    a_big   = {ea_q, ma_q} >= {eb_q, mb_q};
    e_big   = a_big ? ea_q : eb_q;
    e_sml   = a_big ? eb_q : ea_q;
    m_big   = a_big ? ma_q : mb_q;
    m_sml   = a_big ? mb_q : ma_q;
    s_big   = a_big ? sa_q : sb_q;
    s_sml   = a_big ? sb_q : sa_q;
    diff    = e_big - e_sml;
    ash     = (32'(diff) > 32'(SW + 2)) ? 32'(SW + 2) : 32'(diff);
    win     = {m_sml, {(SW + 2){1'b0}}} >> ash;
    small_n = {win[WW-1 -: SW+2], |win[SW-1:0]};
  end

  logic [XW:0] sum_n;
  always_comb begin
    if (eff_sub_q) sum_n = {1'b0, big_q} - {1'b0, small_q};
    else           sum_n = {1'b0, big_q} + {1'b0, small_q};
  end

  // Normalise: carry shifts right, otherwise left by clamped leading-zero count
  logic [31:0]   lz, lim, nsh;
  logic [XW-1:0] mant_n;
  logic [EW-1:0] exp_norm;

  always_comb begin
    lz = 32'(XW);
    for (int i = 0; i < int'(XW); i++) begin
      if (sum_q[i]) lz = 32'(int'(XW) - 1 - i);
    end
    lim = 32'(exp_q) - 32'd1;
    nsh = (lz < lim) ? lz : lim;
    if (sum_q[XW]) begin
      mant_n   = {sum_q[XW:2], sum_q[1] | sum_q[0]};
      exp_norm = exp_q + EW'(1);
    end else begin
      mant_n   = sum_q[XW-1:0] << nsh;
      exp_norm = exp_q - EW'(nsh);
    end
  end

  // Round to nearest even, repack, overflow to Inf
  logic              up, zero_n, inf_n, nan_n;
  logic [RW-1:0]     rsig;
  logic [EW-1:0]     efull;
  logic [FRAC_W-1:0] frac_n;
  logic [W-1:0]      res_n;

  always_comb begin
    up     = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rsig   = {1'b0, mant_q[XW-1:3]} + RW'(up);
    frac_n = rsig[FRAC_W-1:0];
    efull  = exp_q;
    if (rsig[SW]) begin
      efull  = exp_q + EW'(1);
      frac_n = '0;
    end else if (!rsig[SW-1]) begin
      efull = '0;
    end
    if (efull >= {1'b0, EXP_ONES}) res_n = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
    else                           res_n = {sign_q, efull[EXP_W-1:0], frac_n};
    if (rsig == '0) res_n = '0;
    if (spec_q)     res_n = spec_res_q;
    zero_n = (res_n[W-2:0] == '0);
    inf_n  = (res_n[W-2:FRAC_W] == EXP_ONES) && (res_n[FRAC_W-1:0] == '0);
    nan_n  = (res_n[W-2:FRAC_W] == EXP_ONES) && (res_n[FRAC_W-1:0] != '0);
  end

  // Datapath and output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Result     <= '0;
      Ready      <= 1'b1;
      Done       <= 1'b0;
      Zero       <= 1'b0;
      Inf        <= 1'b0;
      Nan        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      exp_q      <= '0;
      big_q      <= '0;
      small_q    <= '0;
      sum_q      <= '0;
      mant_q     <= '0;
    end else begin
      Ready <= ready_n;
      Done  <= done_n;
      if (load) begin
        a_q   <= AddendA;
        b_q   <= AddendB;
        sub_q <= Sub;
      end
      case (state)
        S_UNPACK: begin
          sa_q       <= sa;
          sb_q       <= sb;
          ea_q       <= (ea == '0) ? EXP_W'(1) : ea;
          eb_q       <= (eb == '0) ? EXP_W'(1) : eb;
          ma_q       <= {|ea, fa};
          mb_q       <= {|eb, fb};
          spec_q     <= spec_n;
          spec_res_q <= spec_res_n;
        end
        S_ALIGN: begin
          sign_q    <= s_big;
          eff_sub_q <= s_big ^ s_sml;
          exp_q     <= {1'b0, e_big};
          big_q     <= {m_big, 3'b000};
          small_q   <= small_n;
        end
        S_ADD: sum_q <= sum_n;
        S_NORM: begin
          mant_q <= mant_n;
          exp_q  <= exp_norm;
        end
        S_ROUND: begin
          Result <= res_n;
          Zero   <= zero_n;
          Inf    <= inf_n;
          Nan    <= nan_n;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_adder_param.sv
// Bench for fp_adder_param: directed vectors plus random operands against an
// exact-integer reference model, for single and half formats.
module tb_fp_adder_param;
  logic        clk, rst;
  logic [31:0] a32, b32, r32;
  logic        sub32, go32, rdy32, dn32, z32, i32, n32;
  logic [15:0] a16, b16, r16;
  logic        sub16, go16, rdy16, dn16, z16, i16, n16;

  int n_assert = 0;
  int n_fail   = 0;

  fp_adder_param u_sp (
    .Clock(clk), .Reset(rst), .AddendA(a32), .AddendB(b32), .Sub(sub32), .Go(go32),
    .Result(r32), .Ready(rdy32), .Done(dn32), .Zero(z32), .Inf(i32), .Nan(n32)
  );

  fp_adder_param #(.EXP_W(5), .FRAC_W(10)) u_hp (
    .Clock(clk), .Reset(rst), .AddendA(a16), .AddendB(b16), .Sub(sub16), .Go(go16),
    .Result(r16), .Ready(rdy16), .Done(dn16), .Zero(z16), .Inf(i16), .Nan(n16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exq);
    n_assert++;
    assert (obs === exq) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exq);
    end
  endtask

  // Exact sum in units of the smallest denormal, then RNE by remainder comparison
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input int ew, input int fw);
    int emax, ea, eb, p, sh, e;
    logic sa, sb, rs;
    logic [319:0] fa, fb, ma, mb, mag, keep, rem, half;
    logic [31:0] qnan, finf;
    emax = (1 << ew) - 1;
    sa = a[ew+fw];
    sb = b[ew+fw] ^ sub;
    ea = int'((a >> fw) & 32'(emax));
    eb = int'((b >> fw) & 32'(emax));
    fa = 320'(a & ((32'd1 << fw) - 32'd1));
    fb = 320'(b & ((32'd1 << fw) - 32'd1));
    qnan = (32'(emax) << fw) | (32'd1 << (fw - 1));
    finf = 32'(emax) << fw;
    if ((ea == emax && fa != 0) || (eb == emax && fb != 0)) return qnan;
    if (ea == emax && eb == emax) return (sa != sb) ? qnan : (finf | (32'(sa) << (ew + fw)));
    if (ea == emax) return finf | (32'(sa) << (ew + fw));
    if (eb == emax) return finf | (32'(sb) << (ew + fw));
    ma = (ea == 0 ? fa : (fa | (320'd1 << fw))) << ((ea == 0 ? 1 : ea) - 1);
    mb = (eb == 0 ? fb : (fb | (320'd1 << fw))) << ((eb == 0 ? 1 : eb) - 1);
    if (ma == 0 && mb == 0) return 32'(sa & sb) << (ew + fw);
    if (sa == sb)      begin mag = ma + mb; rs = sa; end
    else if (ma >= mb) begin mag = ma - mb; rs = sa; end
    else               begin mag = mb - ma; rs = sb; end
    if (mag == 0) return 32'd0;
    if (mag < (320'd1 << (fw + 1))) return (32'(rs) << (ew + fw)) | 32'(mag);
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    sh   = p - fw;
    keep = mag >> sh;
    rem  = mag - (keep << sh);
    half = 320'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    if (keep == (320'd1 << (fw + 1))) begin keep = keep >> 1; sh++; end
    e = sh + 1;
    if (e >= emax) return finf | (32'(rs) << (ew + fw));
    return (32'(rs) << (ew + fw)) | (32'(e) << fw) | 32'(keep - (320'd1 << fw));
  endfunction

  // {Zero, Inf, Nan} implied by a result encoding
  function automatic logic [2:0] flags_of(input logic [31:0] r, input int ew, input int fw);
    logic [31:0] e, f, emax;
    emax = (32'd1 << ew) - 32'd1;
    e = (r >> fw) & emax;
    f = r & ((32'd1 << fw) - 32'd1);
    return {e == 0 && f == 0, e == emax && f == 0, e == emax && f != 0};
  endfunction

  // One operation on either instance: latency, result+flags, single-cycle Done
  task automatic op(input bit h, input logic [31:0] a, input logic [31:0] b, input logic sub,
                    input logic [31:0] expv, input string tag);
    int ew, fw, lat;
    logic [63:0] obs;
    ew = h ? 5 : 8;
    fw = h ? 10 : 23;
    @(negedge clk);
    if (h) begin a16 = a[15:0]; b16 = b[15:0]; sub16 = sub; go16 = 1'b1; end
    else   begin a32 = a;       b32 = b;       sub32 = sub; go32 = 1'b1; end
    @(posedge clk);
    #1;
    go16 = 1'b0;
    go32 = 1'b0;
    check({tag, " ready_low"}, 64'(h ? rdy16 : rdy32), 64'd0);
    lat = 0;
    obs = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (h ? dn16 : dn32) begin
        lat = k;
        obs = h ? {29'd0, z16, i16, n16, 16'd0, r16} : {29'd0, z32, i32, n32, r32};
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'd5);
    check({tag, " result"}, obs, {29'd0, flags_of(expv, ew, fw), expv});
    @(posedge clk);
    #1;
    check({tag, " done_ready"}, h ? {62'd0, dn16, rdy16} : {62'd0, dn32, rdy32}, 64'd1);
  endtask

  initial begin
    logic [31:0] a, b, msk, emx, ev;
    logic [31:0] hx_a[3], hx_b[3];
    logic        hx_s[3], s, seen;
    logic [4:0]  dpat;
    int          lat, ew, fw;
    bit          h;

    rst = 1'b1;
    a32 = '0; b32 = '0; sub32 = 1'b0; go32 = 1'b0;
    a16 = '0; b16 = '0; sub16 = 1'b0; go16 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_sp", {26'd0, r32, rdy32, dn32, z32, i32, n32}, {26'd0, 32'd0, 5'b10000});
    check("reset_hp", {42'd0, r16, rdy16, dn16, z16, i16, n16}, {42'd0, 16'd0, 5'b10000});
    rst = 1'b0;

    op(0, 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, "add_1p5_2p25");
    op(0, 32'h80000000, 32'h00000000, 1'b0, 32'h00000000, "negzero_poszero");
    op(0, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, "negzero_minus_zero");
    op(0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, "exact_cancel");
    op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, "overflow");
    op(0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, "inf_minus_inf");
    op(0, 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, "inf_plus_finite");
    op(0, 32'h7FA00001, 32'h3F800000, 1'b0, 32'h7FC00000, "nan_input");
    op(0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, "denorm_add");
    op(0, 32'h00400000, 32'h00400000, 1'b0, 32'h00800000, "denorm_to_normal");
    op(0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, "tie_even_down");
    op(0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, "tie_odd_up");
    op(0, 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, "normal_to_denorm");
    op(1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, "hp_one_plus_one");
    op(1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, "hp_overflow");
    op(1, 32'h0001, 32'h8001, 1'b1, 32'h0002, "hp_denorm_sub");

    // Random operands, alternating formats, biased toward close magnitudes and edges
    for (int t = 0; t < 60; t++) begin
      h   = t[0];
      ew  = h ? 5 : 8;
      fw  = h ? 10 : 23;
      msk = h ? 32'h0000FFFF : 32'hFFFFFFFF;
      emx = ((32'd1 << ew) - 32'd1) << fw;
      a = $urandom & msk;
      b = $urandom & msk;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        1: b = (a ^ 32'($urandom_range(0, 15))) ^ (32'($urandom_range(0, 1)) << (ew + fw));
        2: a = a & ~emx;
        3: b = (a - (32'($urandom_range(0, 3)) << fw)) & msk;
        4: a = ($urandom_range(0, 1) != 0) ? (a | emx) : ((a | emx) & ~((32'd1 << fw) - 32'd1));
        5: begin a = a & ~emx; b = b & ~emx; end
        default: ;
      endcase
      op(h, a, b, s, ref_add(a, b, s, ew, fw), h ? "rand_hp" : "rand_sp");
    end

    // Go pulsed while busy is ignored and does not disturb the latched operands
    @(negedge clk);
    a32 = 32'h3FC00000; b32 = 32'h40100000; sub32 = 1'b0; go32 = 1'b1;
    @(posedge clk);
    #1 go32 = 1'b0;
    lat = 0; seen = 1'b0; ev = '0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 2) begin a32 = 32'h7F800000; b32 = 32'hFF800000; go32 = 1'b1; end
      if (k == 3) go32 = 1'b0;
      @(posedge clk);
      #1;
      if (dn32) begin
        if (lat == 0) begin lat = k; ev = r32; end
        else seen = 1'b1;
      end
    end
    check("busy_go latency", 64'(lat), 64'd5);
    check("busy_go result", 64'(ev), 64'h40700000);
    check("busy_go no_extra_done", 64'(seen), 64'd0);
    check("busy_go ready", 64'(rdy32), 64'd1);

    // Go held high: back-to-back operations, Done every five cycles
    for (int i = 0; i < 3; i++) begin
      hx_a[i] = $urandom;
      hx_b[i] = $urandom;
      hx_s[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    a32 = hx_a[0]; b32 = hx_b[0]; sub32 = hx_s[0]; go32 = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i < 2) begin a32 = hx_a[i+1]; b32 = hx_b[i+1]; sub32 = hx_s[i+1]; end
      else go32 = 1'b0;
      dpat = '0; ev = '0;
      for (int k = 1; k <= 5; k++) begin
        @(posedge clk);
        #1;
        dpat[k-1] = dn32;
        if (k == 5) ev = r32;
      end
      check("held_go done_pattern", 64'(dpat), 64'h10);
      check("held_go result", 64'(ev), 64'(ref_add(hx_a[i], hx_b[i], hx_s[i], 8, 23)));
    end
    @(posedge clk);
    #1;
    check("held_go end_ready", 64'(rdy32), 64'd1);

    // Reset two cycles into an operation abandons it
    @(negedge clk);
    a32 = 32'h3F800000; b32 = 32'h3F800000; sub32 = 1'b0; go32 = 1'b1;
    @(posedge clk);
    #1 go32 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_reset outputs", {26'd0, r32, rdy32, dn32, z32, i32, n32}, {26'd0, 32'd0, 5'b10000});
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 seen = seen | dn32;
    end
    check("mid_reset no_done", 64'(seen), 64'd0);
    check("mid_reset idle", {31'd0, r32, rdy32}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
